// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the 8x8 signed shift-add multiplier.
package mul_pkg;

    localparam int WIDTH  = 8;
    localparam int PROD_W = 2 * WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ACCUM = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/shift_add_sequencer_if.sv
// Handshake, operand/result and shift-register control bundle of the sequencer.
interface shift_add_sequencer_if #(
    parameter int WIDTH = mul_pkg::WIDTH
);
    logic                   start;
    logic [WIDTH-1:0]       a_in;
    logic [WIDTH-1:0]       b_in;
    logic [WIDTH-1:0]       num_a;
    logic [WIDTH-1:0]       num_b;
    logic                   load;
    logic                   en;
    logic [2*WIDTH-1:0]     shl_value;
    logic                   shr_lsb;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;
    logic                   done;

    // master: requester plus the upstream shift registers; slave: the sequencer
    modport master (
        output start, a_in, b_in, shl_value, shr_lsb,
        input  num_a, num_b, load, en, product, busy, done
    );

    modport slave (
        input  start, a_in, b_in, shl_value, shr_lsb,
        output num_a, num_b, load, en, product, busy, done
    );
endinterface

// File: rtl/signed_magnitude_split.sv
// Combinational split of a two's-complement value into sign and unsigned magnitude.
module signed_magnitude_split #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    output logic             sign,
    output logic [WIDTH-1:0] magnitude
);

    assign sign = value[WIDTH-1];
    // Most negative value maps to 2^(WIDTH-1), still representable unsigned.
    assign magnitude = sign ? ((~value) + WIDTH'(1)) : value;

endmodule

// File: rtl/shift_add_sequencer.sv
// Control/accumulate stage of the signed shift-add multiplier.
// Define MUL_EARLY_TERM_EN to stop accumulating once the remaining multiplier bits are zero.
module shift_add_sequencer #(
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_add_sequencer_if.slave bus
);
    import mul_pkg::*;

    localparam int ACC_W = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     num_a_reg, num_b_reg;
    logic                 neg_reg;
    logic [ACC_W-1:0]     acc_reg;
    logic [ACC_W-1:0]     product_reg;
    logic [CNT_W-1:0]     count_reg;

    logic [WIDTH-1:0]     op_val  [2];
    logic [WIDTH-1:0]     op_mag  [2];
    logic                 op_sign [2];

    assign op_val[0] = bus.a_in;
    assign op_val[1] = bus.b_in;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_split
            signed_magnitude_split #(.WIDTH(WIDTH)) u_split (
                .value     (op_val[gi]),
                .sign      (op_sign[gi]),
                .magnitude (op_mag[gi])
            );
        end
    endgenerate

    logic last_bit;
    assign last_bit = (count_reg == CNT_W'(WIDTH - 1));

`ifdef MUL_EARLY_TERM_EN
    logic [CNT_W:0] shift_amt;
    logic           rest_zero;
    assign shift_amt = {1'b0, count_reg} + (CNT_W + 1)'(1);
    assign rest_zero = ((num_b_reg >> shift_amt) == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
`ifdef MUL_EARLY_TERM_EN
                state_next = (num_b_reg == '0) ? FIX : ACCUM;
`else
                state_next = ACCUM;
`endif
            end
            ACCUM: begin
`ifdef MUL_EARLY_TERM_EN
                if (last_bit || rest_zero) begin
                    state_next = FIX;
                end
`else
                if (last_bit) begin
                    state_next = FIX;
                end
`endif
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_a_reg   <= '0;
            num_b_reg   <= '0;
            neg_reg     <= 1'b0;
            acc_reg     <= '0;
            count_reg   <= '0;
            product_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        neg_reg   <= op_sign[0] ^ op_sign[1];
                        num_a_reg <= op_mag[0];
                        num_b_reg <= op_mag[1];
                    end
                end
                LOAD: begin
                    acc_reg   <= '0;
                    count_reg <= '0;
                end
                ACCUM: begin
                    // shl_value/shr_lsb already reflect this bit position
                    if (bus.shr_lsb) begin
                        acc_reg <= acc_reg + bus.shl_value;
                    end
                    count_reg <= count_reg + CNT_W'(1);
                end
                FIX: begin
                    product_reg <= neg_reg ? (-acc_reg) : acc_reg;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.num_a   = num_a_reg;
    assign bus.num_b   = num_b_reg;
    assign bus.load    = (state_reg == LOAD);
    assign bus.en      = (state_reg == ACCUM);
    assign bus.done    = (state_reg == DONE);
    assign bus.busy    = (state_reg != IDLE);
    assign bus.product = product_reg;

endmodule
